// File: rtl/mem_stream_reader_pkg.sv
// Shared types for mem_stream_reader: FSM state encoding and the buffered beat record.
// When MEM_STREAM_READER_ERR_EN is defined each beat also carries an error flag.
package mem_stream_reader_pkg;

    // Width of the data field stored per beat; the top's DATA_WIDTH must match this.
    localparam int BEAT_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic [BEAT_DATA_WIDTH-1:0] data;
        logic                       last;
`ifdef MEM_STREAM_READER_ERR_EN
        logic                       err;
`endif
    } beat_t;

endpackage

// File: rtl/mem_stream_reader_buf.sv
// Circular response buffer of beat_t entries for mem_stream_reader.
// Pointers wrap at DEPTH, so non-power-of-two depths work. The read port shows the
// head entry while non-empty and all zeros when empty, which keeps the stream
// outputs at zero after reset and between bursts.
module mem_stream_reader_buf
    import mem_stream_reader_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  beat_t                      push_beat_i,
    input  logic                       pop_i,
    output beat_t                      pop_beat_o,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    beat_t             mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage write; contents need no reset because the read port is masked when empty.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem[wr_ptr_q] <= push_beat_i;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop in the same cycle keep the count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            if (pop_i) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            if (push_i && !pop_i) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop_i && !push_i) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    assign occupancy_o = count_q;
    assign pop_beat_o  = (count_q != '0) ? mem[rd_ptr_q] : '0;

endmodule

// File: rtl/mem_stream_reader.sv
// mem_stream_reader: accepts a burst command (start address, beats-1), issues word reads on a
// req/gnt/rvalid memory port and replays the returned words as a valid/ready stream with last.
// Reads are credit-limited: a request is only raised while outstanding reads plus buffered
// beats are below DEPTH, so every granted read is guaranteed a buffer slot.
// Optional build macro MEM_STREAM_READER_ERR_EN adds mem_err_i / err_o: an erroring read
// marks its beat and every later beat of the burst (data forced to 0), stops further requests,
// and the missing beats are synthesised so the burst still ends with last_o.
//
// Handshakes: a transfer happens on a rising edge where valid and ready (or req and gnt) are
// both high; valid/req, once raised, hold their payload stable until that transfer.
module mem_stream_reader
    import mem_stream_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = BEAT_DATA_WIDTH,
    parameter int LEN_WIDTH  = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
`ifdef MEM_STREAM_READER_ERR_EN
    input  logic                  mem_err_i,
    output logic                  err_o,
`endif
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  last_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  busy_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;
    localparam int REM_W = LEN_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(STEP - ADDR_WIDTH'(1));

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [REM_W-1:0]      rem_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  push_idx_q;
    logic [CNT_W-1:0]      outstanding_q;
    logic [CNT_W-1:0]      occupancy;

    logic  cmd_fire;
    logic  credit_ok;
    logic  gnt_fire;
    logic  rd_accept;
    logic  synth_push;
    logic  push;
    logic  pop;
    beat_t push_beat;
    beat_t pop_beat;

    assign cmd_fire  = (state_q == IDLE) && cmd_valid_i;
    assign credit_ok = (SUM_W'(outstanding_q) + SUM_W'(occupancy)) < SUM_W'(DEPTH);
    assign gnt_fire  = mem_req_o && mem_gnt_i;
    // Read data arriving with nothing outstanding belongs to an abandoned burst.
    assign rd_accept = mem_rvalid_i && (outstanding_q != '0);
    assign push      = rd_accept || synth_push;
    assign pop       = valid_o && ready_i;

`ifdef MEM_STREAM_READER_ERR_EN
    logic err_seen_q;
    logic err_now;

    assign err_now    = err_seen_q || (rd_accept && mem_err_i);
    assign mem_req_o  = (state_q == ISSUE) && credit_ok && !err_seen_q;
    // After an error, unissued beats are filled in once all real reads have returned,
    // which keeps the buffer in burst order.
    assign synth_push = (state_q == ISSUE) && err_seen_q && (outstanding_q == '0) && credit_ok;
    assign err_o      = pop_beat.err;

    // Sticky per-burst error flag, cleared when a new command is accepted.
    always_ff @(posedge clk_i) begin
        if (rst_i || cmd_fire) begin
            err_seen_q <= 1'b0;
        end else if (rd_accept && mem_err_i) begin
            err_seen_q <= 1'b1;
        end
    end

    // Assemble the beat written into the buffer; errored beats carry zero data.
    always_comb begin
        push_beat      = '0;
        push_beat.last = (push_idx_q == len_q);
        push_beat.err  = err_now;
        push_beat.data = err_now ? '0 : BEAT_DATA_WIDTH'(mem_rdata_i);
    end
`else
    assign mem_req_o  = (state_q == ISSUE) && credit_ok;
    assign synth_push = 1'b0;

    // Assemble the beat written into the buffer.
    always_comb begin
        push_beat      = '0;
        push_beat.last = (push_idx_q == len_q);
        push_beat.data = BEAT_DATA_WIDTH'(mem_rdata_i);
    end
`endif

    // Burst sequencing: IDLE accepts a command, ISSUE walks the addresses, DRAIN waits for last.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            len_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        addr_q  <= cmd_addr_i & ALIGN_MASK;
                        rem_q   <= REM_W'(cmd_len_i) + REM_W'(1);
                        len_q   <= cmd_len_i;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (gnt_fire || synth_push) begin
                        if (gnt_fire) begin
                            addr_q <= addr_q + STEP;
                        end
                        rem_q <= rem_q - REM_W'(1);
                        if (rem_q == REM_W'(1)) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && last_o) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outstanding-read count and position of the next beat entering the buffer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outstanding_q <= '0;
            push_idx_q    <= '0;
        end else begin
            if (cmd_fire) begin
                push_idx_q <= '0;
            end else if (push) begin
                push_idx_q <= push_idx_q + LEN_WIDTH'(1);
            end
            if (gnt_fire && !rd_accept) begin
                outstanding_q <= outstanding_q + CNT_W'(1);
            end else if (rd_accept && !gnt_fire) begin
                outstanding_q <= outstanding_q - CNT_W'(1);
            end
        end
    end

    mem_stream_reader_buf #(
        .DEPTH(DEPTH)
    ) u_buf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_beat_i (push_beat),
        .pop_i       (pop),
        .pop_beat_o  (pop_beat),
        .occupancy_o (occupancy)
    );

    assign cmd_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign mem_addr_o  = addr_q;
    assign valid_o     = (occupancy != '0);
    assign data_o      = DATA_WIDTH'(pop_beat.data);
    assign last_o      = pop_beat.last;

endmodule

// File: tb/tb_mem_stream_reader.sv
// Testbench for mem_stream_reader: randomized memory responder and stream sink, with a
// reference model that expands each command into its expected address list and beat list.
// Build with MEM_STREAM_READER_ERR_EN defined to also exercise the error path.
module tb_mem_stream_reader;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LW    = 8;
    localparam int DEPTH = 4;
    localparam int W     = DW + 2;   // {err, last, data}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_i = 1'b1;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic [AW-1:0] cmd_addr_i;
    logic [LW-1:0] cmd_len_i;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic          mem_req_o;
    logic [AW-1:0] mem_addr_o;
    logic          mem_gnt_i;
    logic          mem_rvalid_i;
    logic [DW-1:0] mem_rdata_i;
    logic          mem_err_i;
    logic          err_o;
    logic [DW-1:0] data_o;
    logic          last_o;
    logic          valid_o;
    logic          ready_i;
    logic          busy_o;

    mem_stream_reader #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .DEPTH(DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .cmd_addr_i   (cmd_addr_i),
        .cmd_len_i    (cmd_len_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
`ifdef MEM_STREAM_READER_ERR_EN
        .mem_err_i    (mem_err_i),
        .err_o        (err_o),
`endif
        .data_o       (data_o),
        .last_o       (last_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .busy_o       (busy_o)
    );

`ifndef MEM_STREAM_READER_ERR_EN
    assign err_o = 1'b0;
`endif

    // ---------------- scoreboard state ----------------
    logic [W-1:0]  exp_q[$];
    logic [AW-1:0] exp_addr_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus knobs
    int gnt_pct   = 100;
    int ready_pct = 100;
    int min_lat   = 0;
    int max_lat   = 0;
    bit err_armed = 1'b0;
    logic [AW-1:0] err_addr = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_msg(input string name, input logic [63:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got 0x%0h with nothing expected (t=%0t)", name, act, $time);
    endtask

    // Contents of the simulated memory at a byte address.
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [W-1:0] obs_beat();
        return {err_o, last_o, data_o};
    endfunction

    // ---------------- memory responder ----------------
    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } pend_t;
    pend_t pend_q[$];
    int    grant_cnt = 0;

    initial begin
        pend_t p;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        mem_err_i    = 1'b0;
        forever begin
            @(negedge clk);
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = '0;
            mem_err_i    = 1'b0;
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                p = pend_q.pop_front();
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = mem_word(p.addr);
                mem_err_i    = err_armed && (p.addr == err_addr);
            end
            mem_gnt_i = ($urandom_range(99) < gnt_pct);
            if (!rst_i && mem_req_o && mem_gnt_i) begin
                p.addr = mem_addr_o;
                p.due  = cyc + 1 + $urandom_range(max_lat - min_lat) + min_lat;
                pend_q.push_back(p);
                grant_cnt++;
            end
        end
    end

    // ---------------- stream sink ----------------
    initial begin
        ready_i = 1'b0;
        forever begin
            @(negedge clk);
            ready_i = ($urandom_range(99) < ready_pct);
        end
    end

    // ---------------- monitor ----------------
    logic          prev_req_stall = 1'b0;
    logic          prev_v_stall   = 1'b0;
    logic [AW-1:0] prev_addr      = '0;
    logic [W-1:0]  prev_beat      = '0;
    logic          err_hit        = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_i) begin
                prev_req_stall = 1'b0;
                prev_v_stall   = 1'b0;
                err_hit        = 1'b0;
            end else begin
                if (prev_req_stall)
                    check("req_hold", {mem_req_o, mem_addr_o}, {1'b1, prev_addr});
                if (prev_v_stall)
                    check("stream_hold", {valid_o, obs_beat()}, {1'b1, prev_beat});
                if (err_hit)
                    check("no_req_after_err", mem_req_o, 0);
                if (mem_req_o && mem_gnt_i) begin
                    if (exp_addr_q.size() == 0) fail_msg("unexpected_grant", mem_addr_o);
                    else check("mem_addr", mem_addr_o, exp_addr_q.pop_front());
                end
                if (valid_o && ready_i) begin
                    if (exp_q.size() == 0) fail_msg("unexpected_beat", obs_beat());
                    else check("stream_beat", obs_beat(), exp_q.pop_front());
                end
                prev_req_stall = mem_req_o && !mem_gnt_i;
                prev_addr      = mem_addr_o;
                prev_v_stall   = valid_o && !ready_i;
                prev_beat      = obs_beat();
                if (!busy_o) err_hit = 1'b0;
`ifdef MEM_STREAM_READER_ERR_EN
                if (mem_rvalid_i && mem_err_i) err_hit = 1'b1;
`endif
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Issue one command (called at a negedge) and expand it in the reference model.
    task automatic send_cmd(input logic [AW-1:0] addr, input logic [LW-1:0] len);
        logic [AW-1:0] base;
        logic [AW-1:0] a;
        int            k;
        bit            ok;
        bit            e;
        ok   = 1'b0;
        k    = -1;
        base = addr & ~32'h3;
        cmd_addr_i  = addr;
        cmd_len_i   = len;
        cmd_valid_i = 1'b1;
        for (int t = 0; t < 500; t++) begin
            if (cmd_ready_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("cmd_accepted", ok, 1);
        if (ok) begin
            for (int i = 0; i <= int'(len); i++) begin
                a = base + AW'(4 * i);
                exp_addr_q.push_back(a);
                if (err_armed && a == err_addr && k < 0) k = i;
                e = (k >= 0) && (i >= k);
                exp_q.push_back({e, (i == int'(len)), e ? '0 : mem_word(a)});
            end
        end
        @(negedge clk);
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input bit flush_addr);
        bit done;
        done = 1'b0;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            #2;
            if (!busy_o && exp_q.size() == 0 && pend_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        check("burst_done", done, 1);
        if (flush_addr) exp_addr_q.delete();
        check("addr_q_empty", exp_addr_q.size(), 0);
        check("cmd_ready_idle", cmd_ready_o, 1);
    endtask

    task automatic check_reset_outputs();
        check("rst_cmd_ready", cmd_ready_o, 1);
        check("rst_mem_req", mem_req_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_last", last_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_mem_addr", mem_addr_o, 0);
        check("rst_data", data_o, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int g0;
        bit reached;
        cmd_addr_i  = '0;
        cmd_len_i   = '0;
        cmd_valid_i = 1'b0;
        rst_i       = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs();
        rst_i = 1'b0;
        @(negedge clk);

        // Directed burst: 4 beats from 0x100, full-rate memory and sink.
        gnt_pct = 100; ready_pct = 100; min_lat = 0; max_lat = 0;
        send_cmd(32'h0000_0100, 8'd3);
        #1;
        check("req_latency", mem_req_o, 1);
        check("busy_in_burst", busy_o, 1);
        check("cmd_ready_in_burst", cmd_ready_o, 0);
        check("first_addr", mem_addr_o, 32'h0000_0100);
        repeat (2) @(negedge clk);
        #1;
        check("rvalid_to_valid", {valid_o, data_o}, {1'b1, mem_word(32'h0000_0100)});
        wait_idle(200, 1'b0);

        // Credit limit: sink stalled, only DEPTH reads may be granted.
        ready_pct = 0;
        g0 = grant_cnt;
        send_cmd(32'h0000_2000, 8'd7);
        repeat (20) @(negedge clk);
        #2;
        check("credit_grants", grant_cnt - g0, DEPTH);
        check("credit_req_low", mem_req_o, 0);
        ready_pct = 100;
        wait_idle(300, 1'b0);

        // Address wrap and single-beat bursts.
        send_cmd(32'hFFFF_FFFC, 8'd1);
        wait_idle(200, 1'b0);
        send_cmd(32'h0000_0ABF, 8'd0);
        wait_idle(200, 1'b0);

        // Randomized traffic: stalled grants, random latency and back-pressure.
        gnt_pct = 50; ready_pct = 50; min_lat = 0; max_lat = 3;
        for (int n = 0; n < 25; n++) begin
            if (n % 5 == 4) send_cmd(32'hFFFF_FFF0 + AW'($urandom_range(15)), LW'($urandom_range(9)));
            else            send_cmd($urandom(), LW'($urandom_range(20)));
            wait_idle(3000, 1'b0);
        end
        send_cmd($urandom(), 8'd40);
        wait_idle(3000, 1'b0);

        // Reset mid-burst after two grants; late read data must be dropped.
        gnt_pct = 100; ready_pct = 100; min_lat = 4; max_lat = 4;
        g0 = grant_cnt;
        send_cmd(32'h0000_0300, 8'd3);
        reached = 1'b0;
        for (int t = 0; t < 50; t++) begin
            if (grant_cnt - g0 >= 2) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
            #2;
        end
        check("two_grants_seen", reached, 1);
        @(negedge clk);
        rst_i = 1'b1;
        exp_q.delete();
        exp_addr_q.delete();
        @(negedge clk);
        #1;
        check_reset_outputs();
        rst_i = 1'b0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            #1;
            check("late_rvalid_ignored", {valid_o, busy_o, mem_req_o}, 3'b000);
        end
        min_lat = 0; max_lat = 0;
        send_cmd(32'h0000_0400, 8'd2);
        wait_idle(200, 1'b0);

`ifdef MEM_STREAM_READER_ERR_EN
        // Error on the second beat: beats 2..4 flagged, no further requests, last intact.
        err_addr  = 32'h0000_0504;
        err_armed = 1'b1;
        send_cmd(32'h0000_0500, 8'd3);
        wait_idle(300, 1'b1);
        err_armed = 1'b0;
        send_cmd(32'h0000_0600, 8'd2);
        wait_idle(200, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog: the sequence above is far shorter than this.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
